// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the instruction memory and its loader.
// Holds the loader state encoding, the program end marker and the byte-address width helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;

  // Byte address width for a word-organised memory: word index plus two byte-offset bits.
  function automatic int byte_addr_bits(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs bytes big-endian into a 32-bit word; word_last/word_dat are combinational with the 4th byte.
// No backpressure: every byte presented while en is high is taken.
module byte_word_packer (
  input  logic        clka,
  input  logic        rsta,
  input  logic        clr,
  input  logic        en,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_last,
  output logic [31:0] word_dat
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // The 4th byte is merged on the fly so the word is ready in the same cycle.
  assign word_dat  = {shift_q, byte_dat};
  assign word_last = en && byte_vld && (byte_cnt == 2'd3);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      byte_cnt <= 2'd0;
      shift_q  <= 24'd0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
      shift_q  <= 24'd0;
    end else if (en && byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[15:0], byte_dat};
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams program bytes into instruction memory until HALT_WORD or the memory is full.
// Write strobe one cycle after the 4th byte of a word; no backpressure, bytes outside a load are dropped.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int                   RAM_WIDTH = 32,
  parameter int                   RAM_DEPTH = 2048,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD = HALT_WORD_DEFAULT,
  localparam int                  ADDR_W    = byte_addr_bits(RAM_DEPTH),
  localparam int                  CNT_W     = ADDR_W - 1
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [RAM_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_W-1:0]     word_count
);

  loader_state_t state_q, state_nxt;

  logic        load_req;
  logic        halt_hit;
  logic        full_hit;
  logic        wr_last;
  logic        pk_en;
  logic        word_last;
  logic [31:0] word_dat;

  assign load_req = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign halt_hit = (wr_data == HALT_WORD);
  assign full_hit = ((word_count + 1'b1) == CNT_W'(RAM_DEPTH));
  assign wr_last  = halt_hit || full_hit;

  // A byte arriving in the WRITE cycle starts the next word, unless this write ends the load.
  assign pk_en = (state_q == ST_COLLECT) || ((state_q == ST_WRITE) && !wr_last);

  byte_word_packer u_packer (
    .clka      (clka),
    .rsta      (rsta),
    .clr       (load_req),
    .en        (pk_en),
    .byte_vld  (rx_valid),
    .byte_dat  (rx_data),
    .word_last (word_last),
    .word_dat  (word_dat)
  );

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) state_q <= ST_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (load_req) state_nxt = ST_COLLECT;
      ST_COLLECT:       if (word_last) state_nxt = ST_WRITE;
      ST_WRITE:         state_nxt = wr_last ? ST_DONE : ST_COLLECT;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  assign wr_en = (state_q == ST_WRITE);
  assign busy  = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign done  = (state_q == ST_DONE);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (load_req) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end
      if (word_last) begin
        wr_addr <= {word_count[CNT_W-2:0], 2'b00};
        wr_data <= word_dat;
      end
      // Halt takes precedence over a coincident full memory.
      if (state_q == ST_WRITE) begin
        word_count <= word_count + 1'b1;
        overflow   <= !halt_hit && full_hit;
      end
    end
  end

endmodule
